// File: rtl/ps2_lcd_pkg.sv
// ps2_lcd_pkg - shared definitions for the PS/2 -> HD44780 console.
//   * PS/2 set-2 scancode constants and the scancode-to-ASCII map
//   * HD44780 command bytes used by the console
//   * FSM state enums and the queued-write record
package ps2_lcd_pkg;

    localparam logic [7:0] SC_BREAK = 8'hF0;
    localparam logic [7:0] SC_EXT   = 8'hE0;
    localparam logic [7:0] SC_ENTER = 8'h5A;
    localparam logic [7:0] SC_BKSP  = 8'h66;
    localparam logic [7:0] SC_ESC   = 8'h76;
    localparam logic [7:0] SC_LEFT  = 8'h6B;
    localparam logic [7:0] SC_RIGHT = 8'h74;

    localparam logic [7:0] LCD_FUNC_SET = 8'h38;  // 8-bit bus, 2 lines, 5x8
    localparam logic [7:0] LCD_DISP_ON  = 8'h0C;  // display on, cursor off
    localparam logic [7:0] LCD_CLEAR    = 8'h01;
    localparam logic [7:0] LCD_ENTRY    = 8'h06;  // increment, no shift
    localparam logic [7:0] LCD_LINE1    = 8'h80;
    localparam logic [7:0] LCD_LINE2    = 8'hC0;
    localparam logic [7:0] ASCII_SPACE  = 8'h20;

    typedef enum logic [1:0] {S_POWERUP, S_IDLE, S_RUN} con_state_t;
    typedef enum logic [1:0] {E_IDLE, E_SETUP, E_HIGH, E_WAIT} eng_state_t;

    typedef struct packed {
        logic       rs;
        logic [7:0] data;
    } lcd_wr_t;

    // Returns 0x00 for codes that have no printable character.
    function automatic logic [7:0] sc_to_ascii(input logic [7:0] sc);
        case (sc)
            8'h1C: return "A";  8'h32: return "B";  8'h21: return "C";
            8'h23: return "D";  8'h24: return "E";  8'h2B: return "F";
            8'h34: return "G";  8'h33: return "H";  8'h43: return "I";
            8'h3B: return "J";  8'h42: return "K";  8'h4B: return "L";
            8'h3A: return "M";  8'h31: return "N";  8'h44: return "O";
            8'h4D: return "P";  8'h15: return "Q";  8'h2D: return "R";
            8'h1B: return "S";  8'h2C: return "T";  8'h3C: return "U";
            8'h2A: return "V";  8'h1D: return "W";  8'h22: return "X";
            8'h35: return "Y";  8'h1A: return "Z";
            8'h45: return "0";  8'h16: return "1";  8'h1E: return "2";
            8'h26: return "3";  8'h25: return "4";  8'h2E: return "5";
            8'h36: return "6";  8'h3D: return "7";  8'h3E: return "8";
            8'h46: return "9";  8'h29: return " ";
            default: return 8'h00;
        endcase
    endfunction

    // Cursor position 0..31 -> set-DDRAM-address command.
    function automatic logic [7:0] pos_to_cmd(input logic [4:0] pos);
        return (pos[4] ? LCD_LINE2 : LCD_LINE1) | {4'h0, pos[3:0]};
    endfunction

endpackage

// File: rtl/lcd_write_engine.sv
// lcd_write_engine - one HD44780 bus write per req.
//   req      : start a write (only honoured when idle; caller waits for done)
//   rs/data  : register select and byte, captured with req
//   done     : one-cycle pulse in the last cycle of the post-write wait
//   LCD_E/LCD_RS/LCD_DATA : bus pins
// Timing: RS/DATA drive one cycle before E rises, E high T_E cycles, then
// T_CMD (or T_CLEAR after a clear command) wait cycles with the bus held.
module lcd_write_engine
    import ps2_lcd_pkg::*;
#(
    parameter int T_E     = 12,
    parameter int T_CMD   = 2000,
    parameter int T_CLEAR = 82000
) (
    input  logic       CLK50MHz,
    input  logic       reset,
    input  logic       req,
    input  logic       rs,
    input  logic [7:0] data,
    output logic       done,
    output logic       LCD_E,
    output logic       LCD_RS,
    output logic [7:0] LCD_DATA
);

    localparam int T_MAX0 = (T_CLEAR > T_CMD) ? T_CLEAR : T_CMD;
    localparam int T_MAX  = (T_MAX0 > T_E) ? T_MAX0 : T_E;
    localparam int CW     = $clog2(T_MAX + 1);
    localparam logic [CW-1:0] E_LOAD   = CW'(T_E - 1);
    localparam logic [CW-1:0] CMD_LOAD = CW'(T_CMD - 1);
    localparam logic [CW-1:0] CLR_LOAD = CW'(T_CLEAR - 1);

    eng_state_t    state, state_n;
    logic [CW-1:0] cnt;

    always_ff @(posedge CLK50MHz) begin
        if (reset) state <= E_IDLE;
        else       state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            E_IDLE:  if (req) state_n = E_SETUP;
            E_SETUP: state_n = E_HIGH;
            E_HIGH:  if (cnt == '0) state_n = E_WAIT;
            E_WAIT:  if (cnt == '0) state_n = E_IDLE;
            default: state_n = E_IDLE;
        endcase
    end

    assign done = (state == E_WAIT) && (cnt == '0);

    always_ff @(posedge CLK50MHz) begin
        if (reset) begin
            cnt      <= '0;
            LCD_E    <= 1'b0;
            LCD_RS   <= 1'b0;
            LCD_DATA <= 8'h00;
        end else begin
            case (state)
                E_IDLE: if (req) begin
                    LCD_RS   <= rs;
                    LCD_DATA <= data;
                end
                E_SETUP: begin
                    LCD_E <= 1'b1;
                    cnt   <= E_LOAD;
                end
                E_HIGH: begin
                    if (cnt == '0) begin
                        LCD_E <= 1'b0;
                        // clear needs the long execution time
                        cnt   <= (!LCD_RS && LCD_DATA == LCD_CLEAR) ? CLR_LOAD : CMD_LOAD;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                E_WAIT: if (cnt != '0) cnt <= cnt - 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/ps2_lcd_console.sv
// ps2_lcd_console - PS/2 set-2 keyboard to 16x2 HD44780 console (8-bit, write-only).
//   CLK50MHz, reset (sync, active high)
//   scancode/scan_valid : byte stream from the keyboard receiver
//   LCD_RS/LCD_E/LCD_RW/LCD_DATA : LCD bus (RW tied low)
//   espera : busy while initialising or executing a key; bytes are dropped then
// Optional: define PS2_EXT_EN to decode E0-prefixed left/right arrow keys.
// Each key is decoded into a short list (max 4) of bus writes that is then
// replayed through lcd_write_engine; the init sequence uses the same list.
module ps2_lcd_console
    import ps2_lcd_pkg::*;
#(
    parameter int T_POWERUP = 750000,
    parameter int T_E       = 12,
    parameter int T_CMD     = 2000,
    parameter int T_CLEAR   = 82000
) (
    input  logic       CLK50MHz,
    input  logic       reset,
    input  logic [7:0] scancode,
    input  logic       scan_valid,
    output logic       LCD_RS,
    output logic       LCD_E,
    output logic       LCD_RW,
    output logic [7:0] LCD_DATA,
    output logic       espera
);

    localparam int PW = $clog2(T_POWERUP + 1);
    localparam logic [PW-1:0] PU_LOAD = PW'(T_POWERUP - 1);

    con_state_t      state, state_n;
    logic [PW-1:0]   pu_cnt;
    logic [4:0]      pos, pos_n, pos_m1, pos_p1;
    logic            brk, brk_n;
`ifdef PS2_EXT_EN
    logic            ext, ext_n;
`endif
    lcd_wr_t [3:0]   wr_q, dec_q;
    logic [1:0]      wr_idx, wr_last, dec_last;
    logic            dec_any;
    logic            pending, req, done;
    logic [7:0]      ascii;

    assign pos_m1 = pos - 5'd1;
    assign pos_p1 = pos + 5'd1;
    assign ascii  = sc_to_ascii(scancode);

    // Key decode: write list and next cursor/flag values for the current byte.
    always_comb begin
        dec_q    = '0;
        dec_last = 2'd0;
        dec_any  = 1'b0;
        pos_n    = pos;
        brk_n    = brk;
`ifdef PS2_EXT_EN
        ext_n    = ext;
`endif
        if (brk) begin
            // byte after F0 is the released key: swallow it
            brk_n = 1'b0;
`ifdef PS2_EXT_EN
            ext_n = 1'b0;
`endif
        end else if (scancode == SC_BREAK) begin
            brk_n = 1'b1;
`ifdef PS2_EXT_EN
        end else if (scancode == SC_EXT) begin
            ext_n = 1'b1;
        end else if (ext) begin
            ext_n = 1'b0;
            if (scancode == SC_LEFT) begin
                pos_n    = pos_m1;
                dec_q[0] = '{rs: 1'b0, data: pos_to_cmd(pos_m1)};
                dec_any  = 1'b1;
            end else if (scancode == SC_RIGHT) begin
                pos_n    = pos_p1;
                dec_q[0] = '{rs: 1'b0, data: pos_to_cmd(pos_p1)};
                dec_any  = 1'b1;
            end
`endif
        end else if (scancode == SC_ENTER) begin
            pos_n    = pos[4] ? 5'd0 : 5'd16;
            dec_q[0] = '{rs: 1'b0, data: pos[4] ? LCD_LINE1 : LCD_LINE2};
            dec_any  = 1'b1;
        end else if (scancode == SC_BKSP) begin
            if (pos != 5'd0) begin
                pos_n    = pos_m1;
                dec_q[0] = '{rs: 1'b0, data: pos_to_cmd(pos_m1)};
                dec_q[1] = '{rs: 1'b1, data: ASCII_SPACE};
                dec_q[2] = '{rs: 1'b0, data: pos_to_cmd(pos_m1)};
                dec_last = 2'd2;
                dec_any  = 1'b1;
            end
        end else if (scancode == SC_ESC) begin
            pos_n    = 5'd0;
            dec_q[0] = '{rs: 1'b0, data: LCD_CLEAR};
            dec_any  = 1'b1;
        end else if (ascii != 8'h00) begin
            pos_n    = pos_p1;   // 31 -> 0 by 5-bit wrap
            dec_q[0] = '{rs: 1'b1, data: ascii};
            dec_any  = 1'b1;
            // the HD44780 address counter does not jump 0x0F -> 0x40 by itself
            if (pos == 5'd15) begin
                dec_q[1] = '{rs: 1'b0, data: LCD_LINE2};
                dec_last = 2'd1;
            end else if (pos == 5'd31) begin
                dec_q[1] = '{rs: 1'b0, data: LCD_LINE1};
                dec_last = 2'd1;
            end
        end
    end

    always_ff @(posedge CLK50MHz) begin
        if (reset) state <= S_POWERUP;
        else       state <= state_n;
    end

    always_comb begin
        state_n = state;
        req     = 1'b0;
        case (state)
            S_POWERUP: if (pu_cnt == '0) state_n = S_RUN;
            S_IDLE:    if (scan_valid && dec_any) state_n = S_RUN;
            S_RUN: begin
                req = !pending;
                if (done && wr_idx == wr_last) state_n = S_IDLE;
            end
            default:   state_n = S_POWERUP;
        endcase
    end

    always_ff @(posedge CLK50MHz) begin
        if (reset) begin
            pu_cnt  <= PU_LOAD;
            pos     <= 5'd0;
            brk     <= 1'b0;
`ifdef PS2_EXT_EN
            ext     <= 1'b0;
`endif
            wr_q    <= '0;
            wr_idx  <= 2'd0;
            wr_last <= 2'd0;
            pending <= 1'b0;
        end else begin
            case (state)
                S_POWERUP: begin
                    if (pu_cnt == '0) begin
                        wr_q[0] <= '{rs: 1'b0, data: LCD_FUNC_SET};
                        wr_q[1] <= '{rs: 1'b0, data: LCD_DISP_ON};
                        wr_q[2] <= '{rs: 1'b0, data: LCD_CLEAR};
                        wr_q[3] <= '{rs: 1'b0, data: LCD_ENTRY};
                        wr_idx  <= 2'd0;
                        wr_last <= 2'd3;
                    end else begin
                        pu_cnt <= pu_cnt - 1'b1;
                    end
                end
                S_IDLE: if (scan_valid) begin
                    pos <= pos_n;
                    brk <= brk_n;
`ifdef PS2_EXT_EN
                    ext <= ext_n;
`endif
                    if (dec_any) begin
                        wr_q    <= dec_q;
                        wr_idx  <= 2'd0;
                        wr_last <= dec_last;
                    end
                end
                S_RUN: begin
                    if (req) pending <= 1'b1;
                    if (done) begin
                        pending <= 1'b0;
                        wr_idx  <= wr_idx + 2'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    lcd_write_engine #(
        .T_E     (T_E),
        .T_CMD   (T_CMD),
        .T_CLEAR (T_CLEAR)
    ) u_eng (
        .CLK50MHz (CLK50MHz),
        .reset    (reset),
        .req      (req),
        .rs       (wr_q[wr_idx].rs),
        .data     (wr_q[wr_idx].data),
        .done     (done),
        .LCD_E    (LCD_E),
        .LCD_RS   (LCD_RS),
        .LCD_DATA (LCD_DATA)
    );

    assign LCD_RW = 1'b0;
    assign espera = (state != S_IDLE);

endmodule

// File: tb/tb_ps2_lcd_console.sv
// tb_ps2_lcd_console - self-checking bench for ps2_lcd_console.
// A bus monitor records every LCD write (sampled at E rise) and checks E
// width, setup/hold and post-write gaps; a keystroke-level model predicts the
// write list and cursor position for each accepted byte.
module tb_ps2_lcd_console;

    localparam int T_POWERUP = 20;
    localparam int T_E       = 2;
    localparam int T_CMD     = 5;
    localparam int T_CLEAR   = 10;

    logic       CLK50MHz = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] scancode = 8'h00;
    logic       scan_valid = 1'b0;
    logic       LCD_RS, LCD_E, LCD_RW, espera;
    logic [7:0] LCD_DATA;

    ps2_lcd_console #(
        .T_POWERUP (T_POWERUP),
        .T_E       (T_E),
        .T_CMD     (T_CMD),
        .T_CLEAR   (T_CLEAR)
    ) dut (
        .CLK50MHz   (CLK50MHz),
        .reset      (reset),
        .scancode   (scancode),
        .scan_valid (scan_valid),
        .LCD_RS     (LCD_RS),
        .LCD_E      (LCD_E),
        .LCD_RW     (LCD_RW),
        .LCD_DATA   (LCD_DATA),
        .espera     (espera)
    );

    always #5 CLK50MHz = ~CLK50MHz;

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h", name, act, exp);
        end
    endtask

    // ---------------- bus monitor ----------------
    logic [8:0] wq[$];     // observed writes {rs,data}
    logic [8:0] exp_q[$];  // expected writes

    initial begin
        logic       e_prev = 1'b0;
        logic [8:0] prev_bus = 9'h0, cur_wr = 9'h0;
        int         ehi = 0, gap = 0, need = 0;
        bit         have_prev = 1'b0;
        forever begin
            @(negedge CLK50MHz);
            if (reset) begin
                e_prev = 1'b0; have_prev = 1'b0; ehi = 0; gap = 0;
            end else begin
                if (LCD_E && !e_prev) begin
                    cur_wr = {LCD_RS, LCD_DATA};
                    wq.push_back(cur_wr);
                    chk("setup", prev_bus, cur_wr);
                    if (have_prev) chk("post-write gap", int'(gap >= need), 1);
                    ehi = 1;
                end else if (LCD_E) begin
                    ehi++;
                    chk("hold E high", {LCD_RS, LCD_DATA}, cur_wr);
                end else if (e_prev) begin
                    chk("E width", ehi, T_E);
                    chk("hold E fall", {LCD_RS, LCD_DATA}, cur_wr);
                    need = (cur_wr == 9'h001) ? T_CLEAR : T_CMD;
                    have_prev = 1'b1;
                    gap = 1;
                end else begin
                    gap++;
                end
                e_prev   = LCD_E;
                prev_bus = {LCD_RS, LCD_DATA};
            end
        end
    end

    // ---------------- reference model ----------------
    localparam logic [7:0] LC[26] = '{8'h1C,8'h32,8'h21,8'h23,8'h24,8'h2B,8'h34,8'h33,8'h43,
                                      8'h3B,8'h42,8'h4B,8'h3A,8'h31,8'h44,8'h4D,8'h15,8'h2D,
                                      8'h1B,8'h2C,8'h3C,8'h2A,8'h1D,8'h22,8'h35,8'h1A};
    localparam logic [7:0] DC[10] = '{8'h45,8'h16,8'h1E,8'h26,8'h25,8'h2E,8'h36,8'h3D,8'h3E,8'h46};

    int mpos = 0;
    bit mbrk = 0, mext = 0;

    function automatic int ascii_of(input logic [7:0] c);
        for (int i = 0; i < 26; i++) if (LC[i] == c) return 65 + i;
        for (int i = 0; i < 10; i++) if (DC[i] == c) return 48 + i;
        if (c == 8'h29) return 32;
        return 0;
    endfunction

    function automatic logic [8:0] addr_cmd(input int p);
        return (p < 16) ? 9'(8'h80 + p) : 9'(8'hC0 + p - 16);
    endfunction

    task automatic model(input logic [7:0] c);
        int a;
        a = ascii_of(c);
        if (mbrk) begin mbrk = 0; mext = 0; return; end
        if (c == 8'hF0) begin mbrk = 1; return; end
`ifdef PS2_EXT_EN
        if (c == 8'hE0) begin mext = 1; return; end
        if (mext) begin
            mext = 0;
            if (c == 8'h6B) begin mpos = (mpos + 31) % 32; exp_q.push_back(addr_cmd(mpos)); end
            if (c == 8'h74) begin mpos = (mpos + 1) % 32;  exp_q.push_back(addr_cmd(mpos)); end
            return;
        end
`endif
        if (c == 8'h5A) begin
            if (mpos < 16) begin mpos = 16; exp_q.push_back(9'h0C0); end
            else           begin mpos = 0;  exp_q.push_back(9'h080); end
        end else if (c == 8'h66) begin
            if (mpos > 0) begin
                mpos--;
                exp_q.push_back(addr_cmd(mpos));
                exp_q.push_back(9'h120);
                exp_q.push_back(addr_cmd(mpos));
            end
        end else if (c == 8'h76) begin
            mpos = 0; exp_q.push_back(9'h001);
        end else if (a != 0) begin
            exp_q.push_back(9'(9'h100 + a));
            mpos++;
            if (mpos == 16) exp_q.push_back(9'h0C0);
            if (mpos == 32) begin mpos = 0; exp_q.push_back(9'h080); end
        end
    endtask

    // ---------------- drivers ----------------
    task automatic send(input logic [7:0] c);
        @(negedge CLK50MHz); scancode = c; scan_valid = 1'b1;
        @(negedge CLK50MHz); scan_valid = 1'b0;
    endtask

    task automatic wait_idle(input int lim);
        int k = 0;
        while (espera && k < lim) begin @(negedge CLK50MHz); k++; end
        if (espera) chk("idle timeout", 1, 0);
    endtask

    task automatic check_writes(input string name);
        chk({name, " count"}, wq.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < wq.size(); i++) chk(name, wq[i], exp_q[i]);
        wq.delete(); exp_q.delete();
    endtask

    // send a byte whose expectation is already in exp_q, then check everything
    task automatic key(input string name, input logic [7:0] c, input int exp_pos);
        bit busy;
        busy = (exp_q.size() != 0);
        send(c);
        chk({name, " espera"}, espera, busy);
        wait_idle(400);
        check_writes(name);
        chk({name, " pos"}, dut.pos, exp_pos);
    endtask

    typedef struct {
        logic [7:0] code;
        int         n;
        logic [8:0] w0, w1, w2;
        int         pos;
    } vec_t;

    vec_t tbl[19];

    initial begin
        logic [7:0] c;
        tbl[0]  = '{8'h1C, 1, 9'h141, 9'h0, 9'h0, 1};
        tbl[1]  = '{8'hF0, 0, 9'h0, 9'h0, 9'h0, 1};
        tbl[2]  = '{8'h1C, 0, 9'h0, 9'h0, 9'h0, 1};
        tbl[3]  = '{8'h32, 1, 9'h142, 9'h0, 9'h0, 2};
        tbl[4]  = '{8'h21, 1, 9'h143, 9'h0, 9'h0, 3};
        tbl[5]  = '{8'h66, 3, 9'h082, 9'h120, 9'h082, 2};
        tbl[6]  = '{8'h76, 1, 9'h001, 9'h0, 9'h0, 0};
        tbl[7]  = '{8'h66, 0, 9'h0, 9'h0, 9'h0, 0};
        tbl[8]  = '{8'h5A, 1, 9'h0C0, 9'h0, 9'h0, 16};
        tbl[9]  = '{8'h23, 1, 9'h144, 9'h0, 9'h0, 17};
        tbl[10] = '{8'h5A, 1, 9'h080, 9'h0, 9'h0, 0};
        tbl[11] = '{8'h0E, 0, 9'h0, 9'h0, 9'h0, 0};
        tbl[12] = '{8'h29, 1, 9'h120, 9'h0, 9'h0, 1};
        tbl[13] = '{8'h45, 1, 9'h130, 9'h0, 9'h0, 2};
        tbl[14] = '{8'h76, 1, 9'h001, 9'h0, 9'h0, 0};
        tbl[15] = '{8'hE0, 0, 9'h0, 9'h0, 9'h0, 0};
`ifdef PS2_EXT_EN
        tbl[16] = '{8'h6B, 1, 9'h0CF, 9'h0, 9'h0, 31};
        tbl[17] = '{8'hE0, 0, 9'h0, 9'h0, 9'h0, 31};
        tbl[18] = '{8'h74, 1, 9'h080, 9'h0, 9'h0, 0};
`else
        tbl[16] = '{8'h6B, 0, 9'h0, 9'h0, 9'h0, 0};
        tbl[17] = '{8'hE0, 0, 9'h0, 9'h0, 9'h0, 0};
        tbl[18] = '{8'h74, 0, 9'h0, 9'h0, 9'h0, 0};
`endif

        // ---- reset values ----
        repeat (3) @(negedge CLK50MHz);
        chk("rst E", LCD_E, 0);
        chk("rst RS", LCD_RS, 0);
        chk("rst RW", LCD_RW, 0);
        chk("rst DATA", LCD_DATA, 0);
        chk("rst espera", espera, 1);
        chk("rst pos", dut.pos, 0);
        chk("rst brk", dut.brk, 0);
        reset = 1'b0;

        // ---- init sequence ----
        @(negedge CLK50MHz);
        chk("init espera high", espera, 1);
        wait_idle(600);
        exp_q = '{9'h038, 9'h00C, 9'h001, 9'h006};
        check_writes("init");

        // ---- directed table ----
        for (int i = 0; i < 19; i++) begin
            if (tbl[i].n > 0) exp_q.push_back(tbl[i].w0);
            if (tbl[i].n > 1) exp_q.push_back(tbl[i].w1);
            if (tbl[i].n > 2) exp_q.push_back(tbl[i].w2);
            key($sformatf("vec%0d", i), tbl[i].code, tbl[i].pos);
        end

        // ---- line wrap: 17 x '1', then on to 32 ----
        for (int i = 1; i <= 32; i++) begin
            exp_q.push_back(9'h131);
            if (i == 16) exp_q.push_back(9'h0C0);
            if (i == 32) exp_q.push_back(9'h080);
            key($sformatf("wrap%0d", i), 8'h16, i % 32);
        end

        // ---- bytes dropped while busy (incl. F0) ----
        send(8'h76);
        chk("drop busy", espera, 1);
        send(8'h1C);
        send(8'hF0);
        wait_idle(400);
        exp_q.push_back(9'h001);
        check_writes("drop clr");
        exp_q.push_back(9'h141);
        key("after drop", 8'h1C, 1);
        mpos = 1; mbrk = 0; mext = 0;

        // ---- randomized keystrokes against the model ----
        for (int it = 0; it < 150; it++) begin
            int r;
            r = $urandom_range(0, 9);
            if (r <= 4)      c = LC[$urandom_range(0, 25)];
            else if (r == 5) c = DC[$urandom_range(0, 9)];
            else if (r == 6) begin
                r = $urandom_range(0, 2);
                c = (r == 0) ? 8'h5A : (r == 1) ? 8'h66 : 8'h76;
            end
            else if (r == 7) c = 8'hF0;
            else if (r == 8) begin
                r = $urandom_range(0, 2);
                c = (r == 0) ? 8'hE0 : (r == 1) ? 8'h6B : 8'h74;
            end
            else             c = 8'($urandom_range(0, 255));
            model(c);
            if (exp_q.size() != 0 && $urandom_range(0, 3) == 0) begin
                send(c);
                chk("rnd espera", espera, 1);
                send(8'($urandom_range(0, 255)));  // must be dropped
                wait_idle(400);
                check_writes("rnd");
                chk("rnd pos", dut.pos, mpos);
            end else begin
                key("rnd", c, mpos);
            end
        end

        // ---- reset in the middle of a write ----
        if (mbrk) begin model(8'h00); key("unbreak", 8'h00, mpos); end
        send(8'h1C);
        begin
            int k = 0;
            while (!LCD_E && k < 50) begin @(negedge CLK50MHz); k++; end
            chk("E seen before abort", LCD_E, 1);
        end
        reset = 1'b1;
        @(negedge CLK50MHz);
        chk("abort E", LCD_E, 0);
        chk("abort DATA", LCD_DATA, 0);
        chk("abort espera", espera, 1);
        chk("abort pos", dut.pos, 0);
        @(negedge CLK50MHz);
        reset = 1'b0;
        wq.delete(); exp_q.delete();
        mpos = 0; mbrk = 0; mext = 0;
        wait_idle(600);
        exp_q = '{9'h038, 9'h00C, 9'h001, 9'h006};
        check_writes("reinit");
        exp_q.push_back(9'h15A);
        key("post reset Z", 8'h1A, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global timeout: actual running required finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/ps2_lcd_console.md
Name: ps2_lcd_console

Overview:
- Converts PS/2 set-2 scancode bytes into characters and edit commands on a 16x2 HD44780-compatible LCD in 8-bit write-only mode.
- Sits between the keyboard UART receive path (byte plus valid strobe) and the LCD pins.
- Owns power-up initialisation, cursor tracking, line wrap and all bus timing.

Parameters:
- T_POWERUP, 750000, cycles waited after reset before the first init command (15 ms at 50 MHz).
- T_E, 12, cycles LCD_E is held high per write.
- T_CMD, 2000, cycles waited after a normal write (40 us).
- T_CLEAR, 82000, cycles waited after a clear (0x01) write (1.64 ms).

Ports:
- CLK50MHz  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- scancode  in  8  PS/2 set-2 byte.
- scan_valid  in  1  one-cycle strobe; scancode is valid in that cycle.
- LCD_RS  out  1  0 = command, 1 = data.
- LCD_E  out  1  LCD enable strobe.
- LCD_RW  out  1  tied to 0.
- LCD_DATA  out  8  LCD bus.
- espera  out  1  busy; high while initialising or while executing a key action.

Behaviour:
- Reset values: LCD_E=0, LCD_RS=0, LCD_RW=0, LCD_DATA=0x00, espera=1, cursor position=0, break flag=0.
- Reset mid-operation aborts any write within one cycle.
- Init sequence, after T_POWERUP idle cycles:
  - commands 0x38, 0x0C, 0x01, 0x06;
  - then espera falls.
- Write primitive:
  - RS and DATA are driven one cycle before E rises.
  - E is high for T_E cycles, then low.
  - RS and DATA are held stable until the post-write wait ends.
  - Post-write wait is T_CLEAR after 0x01, otherwise T_CMD.
- Decoder:
  - Byte 0xF0 sets the break flag. The next byte clears the flag and is discarded.
  - Bytes not in the map are ignored; espera stays low.
- Character map:
  - Letters (uppercase ASCII): 1C A, 32 B, 21 C, 23 D, 24 E, 2B F, 34 G, 33 H, 43 I, 3B J, 42 K, 4B L, 3A M, 31 N, 44 O, 4D P, 15 Q, 2D R, 1B S, 2C T, 3C U, 2A V, 1D W, 22 X, 35 Y, 1A Z.
  - Digits and space: 45 '0', 16 '1', 1E '2', 26 '3', 25 '4', 2E '5', 36 '6', 3D '7', 3E '8', 46 '9', 29 space.
- Control keys:
  - 5A enter: set address to the start of the other line (0x80 <-> 0xC0).
  - 66 backspace: at position 0, no action. Otherwise pos-1; set address; write 0x20; set address again.
  - 76 escape: write 0x01; position=0.
- Cursor position 0..31 maps to DDRAM 0x00..0x0F (line 1) and 0x40..0x4F (line 2). A command is 0x80|addr.
- Printable character: write data (RS=1), then pos+1.
  - pos 16: also issue 0xC0.
  - pos 32: wraps to 0 and issues 0x80 (no clear).
- espera rises the cycle after an accepted scan_valid and falls when the last write's wait ends.
- scan_valid while espera=1 is dropped, including 0xF0. The break flag is not altered by a dropped byte.

Optional Feature:
- PS2_EXT_EN defined:
  - 0xE0 sets an ext flag. The following make code is interpreted as extended.
  - E0 6B (left) moves the cursor -1 and E0 74 (right) moves it +1, each wrapping 0<->31, via an address-set command.
  - Other extended codes are ignored.
  - E0 F0 xx is discarded as a break.
- PS2_EXT_EN undefined: 0xE0 is an unmapped byte and is ignored; the following code decodes normally.

Decomposition:
- Package ps2_lcd_pkg holds:
  - scancode constants and the scancode-to-ASCII function;
  - LCD command constants (0x38, 0x0C, 0x01, 0x06, 0x80, 0xC0);
  - the state enum.
- Sub-module lcd_write_engine:
  - inputs: req, rs, byte;
  - output: done;
  - implements the E timing and the post-write wait.
- Top level holds the init sequencer, decoder and cursor FSM.

Test Plan (T_POWERUP=20, T_E=2, T_CMD=5, T_CLEAR=10):
- Reset release -> writes 0x38, 0x0C, 0x01, 0x06 (RS=0) in order; espera goes 1 then 0; 10-cycle gap after 0x01.
- Bytes 1C, F0, 1C -> exactly one data write 0x41 with RS=1; position=1.
- 17 x 0x16 -> sixteen 0x31 writes, then command 0xC0, then the 17th 0x31; position=17.
- 66 at position 0 -> no bus activity. 66 at position 3 -> writes 0x82, 0x20 (RS=1), 0x82.
- scan_valid=0x1C while espera=1 -> ignored, no extra write. 76 -> 0x01 followed by a 10-cycle wait; position=0.
- With PS2_EXT_EN: E0 6B at position 0 -> command 0xCF; position=31.
